mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing front-end that sits directly upstream of the `Memory_Cell` array. It accepts one read or write request at a time over a valid/ready handshake and splits the flat address into one-hot row and column selects. It drives single-cycle `Rd`/`Wr` strobes with one setup cycle, captures read data from the selected cell, and returns a response over a second valid/ready handshake.

## Interface
- `N`, default 2: address bits per dimension; the array is 2^N rows x 2^N columns.
- `DW`, default 8: data width, matching the cell width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: a request is presented.
- `req_ready`  out  1: the controller can accept a request.
- `req_wr`  in  1: 1 = write, 0 = read.
- `req_addr`  in  2N: {row[N-1:0], col[N-1:0]}.
- `req_wdata`  in  DW: write data.
- `row_sel`  out  2^N: one-hot row select to the array.
- `col_sel`  out  2^N: one-hot column select to the array.
- `cell_rd`  out  1: read strobe to the selected cell.
- `cell_wr`  out  1: write strobe to the selected cell.
- `cell_wdata`  out  DW: data to the array.
- `cell_rdata`  in  DW: data from the selected cell.
- `rsp_valid`  out  1: a response is available.
- `rsp_ready`  in  1: the consumer accepts the response.
- `rsp_wr`  out  1: echoes the request type.
- `rsp_rdata`  out  DW: captured read data.

## Operation
- The FSM has four states: IDLE, SETUP, STROBE and RESP. It is binary-encoded, and any unused encoding returns to IDLE.
- **IDLE:**
  - `req_ready`=1.
  - When `req_valid`&&`req_ready`, latch `req_wr`, `req_addr` and `req_wdata`, then go to SETUP.
- **SETUP (1 cycle):**
  - `row_sel`=1<<addr[2N-1:N] and `col_sel`=1<<addr[N-1:0].
  - `cell_wdata` = latched wdata.
  - Both strobes are 0.
  - Go to STROBE.
- **STROBE (1 cycle):**
  - Selects and `cell_wdata` are unchanged from SETUP.
  - `cell_wr`=1 for a write, or `cell_rd`=1 for a read; never both.
  - On the exiting edge, a read captures `cell_rdata` into `rsp_rdata`.
  - A write leaves `rsp_rdata` unchanged.
  - Go to RESP.
- **RESP:**
  - `rsp_valid`=1, `rsp_wr` = latched type.
  - Selects and strobes are 0.
  - Stay in RESP while `rsp_ready`=0; `rsp_valid`, `rsp_wr` and `rsp_rdata` must remain stable.
  - When `rsp_ready`=1, go to IDLE.
- `req_ready`=0 in SETUP, STROBE and RESP. Requests presented in those states are ignored and are not queued.
- Every `req_addr` value is in range. The select decode is a full one-hot, with exactly one bit set in SETUP and STROBE.
- **Reset (`rst_n`=0, at any time including mid-access):**
  - State returns to IDLE immediately, without waiting for a clock edge.
  - All outputs are 0: `row_sel`, `col_sel`, strobes, `cell_wdata`, `rsp_valid`, `rsp_wr`, `rsp_rdata`.
  - The exception is `req_ready`, which is 1 because the state is IDLE.
  - An aborted write may or may not have updated the cell; nothing beyond this is guaranteed.

## Timing
- Let edge E0 be the edge at which the request is accepted.
- SETUP occupies the cycle E0..E1, STROBE occupies E1..E2, and `rsp_valid` rises after E2.
- Request-to-response latency is therefore 3 cycles. The strobe is exactly 1 cycle wide.
- Address and data are stable one full cycle before the strobe and throughout it; they drop at E2.
- Read data is sampled at E2, the end of the strobe cycle. `cell_rdata` must be valid within that cycle.
- If `rsp_ready` is already 1 when `rsp_valid` rises, the response is consumed at E3 and IDLE is entered after E3.
- Maximum throughput is one access per 4 cycles. The next accept can occur at the earliest at E4.
- All outputs are registered or decoded from registered state only; there is no combinational path from `req_*` to any output.

## Test plan
- **Reset:** assert `rst_n`=0 mid-simulation.
  - All outputs are 0 except `req_ready`=1.
  - Release reset; there is no activity until `req_valid` is driven.
- **Write:** N=2, write addr 0x5 with data 0xA5.
  - SETUP: `row_sel`=0010, `col_sel`=0010, `cell_wdata`=0xA5, strobes 0.
  - STROBE: `cell_wr`=1 for exactly one cycle.
  - `rsp_valid`=1 with `rsp_wr`=1 three cycles after accept.
- **Read-back:** read addr 0x5 with the cell model returning 0xA5.
  - `cell_rd` pulses for one cycle.
  - `rsp_rdata`=0xA5 and `rsp_wr`=0.
  - Repeat with addr 0xF: `row_sel`=`col_sel`=1000.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - The response is held stable and `req_ready` stays 0.
  - A `req_valid` pulse during this window is ignored, with no second access.
- **Back-to-back:** `rsp_ready` tied to 1 and a continuous stream of 3 reads.
  - Accepts are spaced exactly 4 cycles apart.
  - Each response matches its own address.
- **Reset mid-access:** drop `rst_n` during STROBE of a write.
  - `cell_wr`, `row_sel` and `col_sel` go to 0 immediately, before the next edge.
  - `rsp_valid` never asserts for that request.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Request sequencer for the Memory_Cell array: one access per request,
// with a setup cycle, a single-cycle strobe and a held response.
module mem_access_ctrl #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2*N-1:0]    req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic [(1<<N)-1:0] row_sel,
    output logic [(1<<N)-1:0] col_sel,
    output logic              cell_rd,
    output logic              cell_wr,
    output logic [DW-1:0]     cell_wdata,
    input  logic [DW-1:0]     cell_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [DW-1:0]     rsp_rdata
);

    localparam int R = 1 << N;
    localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]     state;
    logic [1:0]     state_nx;
    logic           wr_q;
    logic [2*N-1:0] addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  rdata_q;
    logic           active;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = req_valid ? SETUP : IDLE;
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Reads sample the cell at the end of the strobe cycle
            if (state == STROBE && !wr_q) begin
                rdata_q <= cell_rdata;
            end
        end
    end

    assign active     = (state == SETUP) || (state == STROBE);
    assign req_ready  = (state == IDLE);
    assign row_sel    = active ? (ONE << addr_q[2*N-1:N]) : '0;
    assign col_sel    = active ? (ONE << addr_q[N-1:0]) : '0;
    assign cell_wdata = active ? wdata_q : '0;
    assign cell_rd    = (state == STROBE) && !wr_q;
    assign cell_wr    = (state == STROBE) && wr_q;
    assign rsp_valid  = (state == RESP);
    assign rsp_wr     = rsp_valid && wr_q;
    assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table, response scoreboard and
// hand-written reset sequences against a behavioural cell array.
module tb_mem_access_ctrl;

    localparam int N  = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [3:0]    req_addr;
    logic [7:0]    req_wdata;
    logic [3:0]    row_sel;
    logic [3:0]    col_sel;
    logic          cell_rd;
    logic          cell_wr;
    logic [7:0]    cell_wdata;
    logic [7:0]    cell_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_wr;
    logic [7:0]    rsp_rdata;

    mem_access_ctrl #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .row_sel(row_sel), .col_sel(col_sel),
        .cell_rd(cell_rd), .cell_wr(cell_wr),
        .cell_wdata(cell_wdata), .cell_rdata(cell_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [3:0] row;
        logic [3:0] col;
        int         stall;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [7:0] rd;
    } rsp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   acc_cyc[$];
    rsp_t sb[$];

    logic [7:0] cmem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] last_rd;

    function automatic int oh_idx(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    assign cell_rdata = cmem[oh_idx(row_sel) * 4 + oh_idx(col_sel)];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cell_wr) cmem[oh_idx(row_sel) * 4 + oh_idx(col_sel)] <= cell_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            accepts++;
            acc_cyc.push_back(cyc);
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("sb_rsp_wr", {31'd0, rsp_wr}, {31'd0, e.wr});
                chk("sb_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rd});
            end
        end
    end

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_sel"}, {24'd0, row_sel, col_sel}, 32'd0);
        chk({nm, "_strobes"}, {30'd0, cell_rd, cell_wr}, 32'd0);
        chk({nm, "_wdata"}, {24'd0, cell_wdata}, 32'd0);
        chk({nm, "_rsp"}, {22'd0, rsp_valid, rsp_wr, rsp_rdata}, 32'd0);
    endtask

    task automatic access(input vec_t v);
        rsp_t e;
        logic [7:0] held;
        req_valid = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wd;
        @(negedge clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        e.wr = v.wr;
        if (v.wr) begin
            ref_mem[v.addr] = v.wd;
        end else begin
            last_rd = ref_mem[v.addr];
        end
        e.rd = last_rd;
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        rsp_ready = (v.stall == 0);
        @(negedge clk);
        chk("setup_row", {28'd0, row_sel}, {28'd0, v.row});
        chk("setup_col", {28'd0, col_sel}, {28'd0, v.col});
        chk("setup_wdata", {24'd0, cell_wdata}, v.wr ? {24'd0, v.wd} : 32'd0);
        chk("setup_strobes", {30'd0, cell_rd, cell_wr}, 32'd0);
        chk("setup_busy", {30'd0, req_ready, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("strobe_sel", {24'd0, row_sel, col_sel}, {24'd0, v.row, v.col});
        chk("strobe_rw", {30'd0, cell_rd, cell_wr}, v.wr ? 32'd1 : 32'd2);
        chk("strobe_busy", {30'd0, req_ready, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_wr", {31'd0, rsp_wr}, {31'd0, v.wr});
        chk("resp_quiet", {22'd0, row_sel, col_sel, cell_rd, cell_wr},
            32'd0);
        held = rsp_rdata;
        for (int k = 0; k < v.stall; k++) begin
            @(posedge clk);
            #1;
            req_valid = (k == 1);
            req_addr  = 4'h0;
            req_wr    = 1'b1;
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_wr", {31'd0, rsp_wr}, {31'd0, v.wr});
            chk("bp_rdata", {24'd0, rsp_rdata}, {24'd0, held});
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_strobes", {30'd0, cell_rd, cell_wr}, 32'd0);
        end
        if (v.stall > 0) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];
    vec_t rd3[3];

    initial begin
        int a0;
        tbl[0] = '{1'b1, 4'h5, 8'hA5, 4'b0010, 4'b0010, 0};
        tbl[1] = '{1'b0, 4'h5, 8'h00, 4'b0010, 4'b0010, 0};
        tbl[2] = '{1'b1, 4'hF, 8'h3C, 4'b1000, 4'b1000, 0};
        tbl[3] = '{1'b0, 4'hF, 8'h00, 4'b1000, 4'b1000, 0};
        tbl[4] = '{1'b1, 4'h9, 8'h77, 4'b0100, 4'b0010, 0};
        tbl[5] = '{1'b0, 4'h9, 8'h00, 4'b0100, 4'b0010, 5};
        tbl[6] = '{1'b1, 4'h6, 8'hE1, 4'b0010, 4'b0100, 2};
        tbl[7] = '{1'b0, 4'h0, 8'h00, 4'b0001, 4'b0001, 0};
        rd3[0] = '{1'b0, 4'h5, 8'h00, 4'b0010, 4'b0010, 0};
        rd3[1] = '{1'b0, 4'h9, 8'h00, 4'b0100, 4'b0010, 0};
        rd3[2] = '{1'b0, 4'h6, 8'h00, 4'b0010, 4'b0100, 0};
        for (int i = 0; i < 16; i++) begin
            cmem[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        last_rd   = 8'h00;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        #1;
        chk_idle_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle_outputs("post_rst_quiet");
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            a0 = accepts;
            access(tbl[i]);
            chk("one_accept", accepts - a0, 32'd1);
        end

        acc_cyc.delete();
        for (int i = 0; i < 3; i++) access(rd3[i]);
        chk("b2b_n", acc_cyc.size(), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 32'd4);
            chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 32'd4);
        end
        chk("sb_drained", sb.size(), 32'd0);

        // Reset while idle, with a nonzero captured read pending
        chk("pre_rst_rdata", {24'd0, rsp_rdata}, {24'd0, last_rd});
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("idle_rst");
        last_rd = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during the strobe cycle of a write
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'h3;
        req_wdata = 8'h5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobe_wr", {31'd0, cell_wr}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_wr_low", {31'd0, cell_wr}, 32'd0);
        chk("abort_sel_low", {24'd0, row_sel, col_sel}, 32'd0);
        chk_idle_outputs("abort_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        access(tbl[1]);
        chk("sb_final", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
